// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the parametrised UART receiver and the
// future transmitter.
//   rx_state_e  : receiver FSM state encoding
//   PAR_EVEN/ODD: parity mode constants
//   baud_cnt_w(): width of a counter that spans one serial bit
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff -- multi-flop synchroniser for a single asynchronous input.
// Flops reset to 1 so an idle-high serial line does not show a false edge
// when reset is released.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output (DEPTH clocks of latency)
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampled mid-bit UART receiver with a valid/ready
// holding register.
// Optional feature: define UART_RX_PARITY_EN to expect a parity bit after
// the last data bit (PARITY_ODD selects odd parity); otherwise parity_err=0.
//
// state         | meaning
// RX_IDLE       | line idle, waiting for rx low
// RX_START      | timing to middle of start bit, reject glitches
// RX_DATA       | sampling DATA_W data bits mid-bit
// RX_PARITY     | sampling parity bit (parity build only)
// RX_STOP       | sampling STOP_BITS stop bits, delivers word on last one
// RX_BREAK_WAIT | last stop bit was 0, wait for line to return high
//
// Ports:
//   clk, rst (async active-low), rxd (async serial in)
//   data/valid/ready : holding register handshake
//   frame_err, parity_err : qualify data while valid=1
//   overrun : sticky, word lost into full register; cleared by handshake
//   busy    : FSM not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int MSB_FIRST    = 1,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  ,parameter logic PARITY_ODD = PAR_EVEN
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int BAUD_W = baud_cnt_w(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  logic rx;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (rxd),
    .q_o   (rx)
  );

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              deliver, deliver_ferr;
  logic              bit_tick, half_tick;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  assign bit_tick  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign half_tick = (baud_q == BAUD_W'(CLKS_PER_BIT / 2 - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    ferr_d       = ferr_q;
    deliver      = 1'b0;
    deliver_ferr = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    perr_d       = perr_q;
`endif
    case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        if (half_tick) begin
          baud_d = '0;
          bit_d  = '0;
          ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_d  = 1'b0;
          perr_d = 1'b0;
`endif
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          baud_d  = '0;
          shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], rx}
                                     : {rx, shift_q[DATA_W-1:1]};
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ rx;
`endif
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_tick) begin
          baud_d  = '0;
          // Even parity: XOR over data and parity bit is 0; odd: 1.
          perr_d  = ((par_q ^ rx) != PARITY_ODD);
          state_d = RX_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      RX_STOP: begin
        if (bit_tick) begin
          baud_d = '0;
          if (!rx) ferr_d = 1'b1;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            deliver      = 1'b1;
            deliver_ferr = ferr_q | ~rx;
            bit_d        = '0;
            state_d      = rx ? RX_IDLE : RX_BREAK_WAIT;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      RX_BREAK_WAIT: begin
        if (rx) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Holding register
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_out_q, ferr_out_d;
  logic              overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic              perr_out_q, perr_out_d;
`endif

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = overrun_q;
`ifdef UART_RX_PARITY_EN
    perr_out_d = perr_out_q;
`endif
    if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (deliver) begin
      // A same-cycle handshake frees the register for the new word.
      if (!valid_q || ready) begin
        data_d     = shift_q;
        valid_d    = 1'b1;
        ferr_out_d = deliver_ferr;
`ifdef UART_RX_PARITY_EN
        perr_out_d = perr_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_out_q <= 1'b0;
`endif
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_out_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_out_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param with default parameters (8N1, 16x, MSB first).
module tb_uart_rx_param;

  localparam int C     = 16;
  localparam int SYNC  = 2;
  localparam int STOPB = 1;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = C/2 + (8 + P + STOPB)*C + 1 + SYNC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_param dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       ferr;
    logic       perr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] d;
    logic       stop_v;
    logic       par_flip;
  } vec_t;

  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, start_cyc = 0, rise_cyc = 0;
  int   n_words = 0, hi_cnt = 0, last_hi_len = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Output monitor: samples 1ns after the falling edge.
  always @(negedge clk) begin
    #1;
    if (valid && !valid_prev) rise_cyc = cyc;
    if (valid) hi_cnt++;
    else if (valid_prev) begin
      last_hi_len = hi_cnt;
      hi_cnt = 0;
    end
    valid_prev = valid;
    if (valid && ready) begin
      n_words++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", data, e.d);
        chk("frame_err", frame_err, e.ferr);
        chk("parity_err", parity_err, e.perr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic par_flip, input int extra_low);
    start_cyc = cyc;
    drive_bit(1'b0, C);
    for (int i = 7; i >= 0; i--) drive_bit(d[i], C);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, C);
`endif
    for (int i = 0; i < STOPB; i++) drive_bit(stop_v, C);
    if (!stop_v && extra_low > 0) drive_bit(1'b0, extra_low);
    rxd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  int   words0;
  logic exp_perr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1};
    vecs[6] = '{8'h07, 1'b1, 1'b0};

    // Reset state
    tick(3);
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    ready = 1'b1;
    tick(4);

    // Table-driven frames, ready held high
    for (int i = 0; i < 7; i++) begin
`ifdef UART_RX_PARITY_EN
      exp_perr = vecs[i].par_flip;
`else
      exp_perr = 1'b0;
`endif
      words0 = n_words;
      sb.push_back('{vecs[i].d, ~vecs[i].stop_v, exp_perr});
      send_frame(vecs[i].d, vecs[i].stop_v, vecs[i].par_flip, 0);
      tick(4);
      #2;
      chk("latency", rise_cyc - start_cyc, LAT);
      chk("valid_len", last_hi_len, 1);
      chk("words", n_words, words0 + 1);
      chk("busy_after", busy, 0);
      tick(2);
    end

    // False start: 5-cycle low glitch
    words0 = n_words;
    drive_bit(1'b0, 5);
    rxd = 1'b1;
    #2;
    chk("fs_busy_high", busy, 1);
    tick(10);
    #2;
    chk("fs_busy_low", busy, 0);
    tick(20);
    #2;
    chk("fs_words", n_words, words0);
    chk("fs_overrun", overrun, 0);

    // Break: stop bit 0, line held low 40 more cycles
    words0 = n_words;
    sb.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 40);
    rxd = 1'b0;
    tick(8);
    #2;
    chk("brk_busy", busy, 1);
    chk("brk_words", n_words, words0 + 1);
    rxd = 1'b1;
    tick(5);
    #2;
    chk("brk_idle", busy, 0);
    tick(40);
    #2;
    chk("brk_no_second", n_words, words0 + 1);

    // Overrun: two words with ready low
    ready = 1'b0;
    sb.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1, 1'b0, 0);
    tick(4);
    #2;
    chk("ovr_first_valid", valid, 1);
    chk("ovr_first_flag", overrun, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    tick(4);
    #2;
    chk("ovr_valid", valid, 1);
    chk("ovr_data_kept", data, 8'h11);
    chk("ovr_flag", overrun, 1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #2;
    chk("ovr_valid_clr", valid, 0);
    chk("ovr_flag_clr", overrun, 0);
    ready = 1'b1;
    tick(2);

    // Reset in the middle of the data bits
    words0 = n_words;
    drive_bit(1'b0, C);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, C);
    rst = 1'b0;
    rxd = 1'b1;
    tick(2);
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid, 0);
    rst = 1'b1;
    tick(4);
    sb.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    tick(4);
    #2;
    chk("mid_rst_words", n_words, words0 + 1);
    chk("mid_rst_overrun", overrun, 0);

    tick(4);
    #2;
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
